riscv_hwloop_bank: RTL and testbench
====================================

Name: riscv_hwloop_bank

Overview:
- Parametrised hardware-loop register bank with built-in loop-end detection, for the RI5CY ID stage.
- Holds start address, end address and iteration counter for N_HWLP loops, written from the EX stage by lp.* setup instructions.
- Compares the current fetch PC against every active loop end and selects the innermost match. It produces the jump request, the jump target and a one-hot decrement.
- Applies the decrement internally, gated by valid_i, so the controller no longer supplies hwlp_dec_cnt_i.

Parameters:
- N_HWLP, 2, number of hardware loops; index 0 is the innermost loop and has the highest priority. Legal range 1..8.
- N_HWLP_BITS, $clog2(N_HWLP) with a minimum of 1, width of the loop select.
- ADDR_W, 32, address width.
- CNT_W, 32, counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- hwlp_start_data_i  in  ADDR_W  start address write data.
- hwlp_end_data_i  in  ADDR_W  end address write data.
- hwlp_cnt_data_i  in  CNT_W  counter write data.
- hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter. Any combination is legal.
- hwlp_regid_i  in  N_HWLP_BITS  loop selected for writing.
- valid_i  in  1  the instruction at current_pc_i retires this cycle.
- current_pc_i  in  ADDR_W  PC of the instruction in the ID stage.
- hwlp_start_addr_o  out  N_HWLP*ADDR_W  all start registers, flattened; loop k occupies bits [k*ADDR_W +: ADDR_W].
- hwlp_end_addr_o  out  N_HWLP*ADDR_W  all end registers, flattened.
- hwlp_counter_o  out  N_HWLP*CNT_W  all counters, flattened.
- hwlp_active_o  out  N_HWLP  bit k = counter[k] != 0.
- hwlp_jump_o  out  1  branch back to the loop start.
- hwlp_targ_addr_o  out  ADDR_W  jump target.
- hwlp_dec_o  out  N_HWLP  one-hot: the loop whose counter is decremented this cycle.

Behaviour:
- Reset (asynchronous, immediate):
  - All start, end and counter registers clear to 0, so hwlp_active_o = 0.
  - hwlp_jump_o = 0, hwlp_targ_addr_o = 0, hwlp_dec_o = 0.
  - Reset asserted mid-loop abandons the loop; there is no pending state.
- Writes take effect one cycle after the enable. A register written in cycle t is visible on the outputs in cycle t+1.
- hwlp_regid_i >= N_HWLP (N_HWLP not a power of 2): the write is dropped silently.
- Match logic is combinational from the registers and current_pc_i:
  - match[k] = active[k] && (current_pc_i == end[k]).
  - sel = lowest k with match[k] set. Any nesting conflict resolves to the innermost loop.
  - No match: hwlp_jump_o = 0, hwlp_dec_o = 0, and hwlp_targ_addr_o holds its last registered value (a registered copy updated on every match).
  - Match and counter[sel] > 1: hwlp_jump_o = 1 and hwlp_targ_addr_o = start[sel].
  - Match and counter[sel] == 1: hwlp_jump_o = 0 (fall through, last iteration).
  - Match: hwlp_dec_o = onehot(sel) in both counter cases.
  - hwlp_dec_o is asserted independent of valid_i; the decrement is applied only when valid_i = 1.
- Counter update for loop k, in priority order:
  1. we[2] && regid == k: counter[k] <= hwlp_cnt_data_i. A write wins over a same-cycle decrement of the same loop.
  2. Otherwise, dec[k] && valid_i: counter[k] <= counter[k] - 1.
  3. Otherwise hold.
- A counter at 0 is never decremented: no wrap to 2^CNT_W-1, since an inactive loop cannot match.
- A write to loop j does not block a decrement of loop k != j in the same cycle.
- A counter write of 0 deactivates the loop immediately on the next cycle.
- start[k] == end[k] (single-instruction body) is legal; the bank jumps to the same PC each retiring cycle.
- valid_i = 0 while matching (stall): outputs stay stable and the counter holds.
- Assertion (simulation only): $onehot0(hwlp_dec_o) in every cycle.

Decomposition:
- Package riscv_hwloop_pkg holds:
  - HWLP_WE_START / HWLP_WE_END / HWLP_WE_CNT bit indices (0, 1, 2).
  - Default N_HWLP.
  - A hwlp_regs_t struct {start, end, cnt} for use by the controller and tracer.
- One natural sub-module: riscv_hwloop_match, a parametrised N-way comparator plus lowest-index priority encoder. It outputs sel, a valid flag and the one-hot vector.

Test Plan:
- Setup loop0 (start=0x100, end=0x10C, cnt=3), drive pc=0x10C with valid_i each visit:
  - jump to 0x100 twice (counter 3→2→1);
  - on the third visit jump=0, dec=01, counter→0;
  - active[0] then drops.
- Nested loops: loop0 end=0x20C cnt=2 and loop1 end=0x20C cnt=5, pc=0x20C:
  - dec=01 and target=loop0 start;
  - loop1 is unchanged until loop0 reaches 0, after which dec=10.
- Same-cycle write and decrement of loop0 (cnt write 7, match with valid):
  - counter=7 next cycle, not 6;
  - concurrent decrement of loop1 with a write to loop0 still decrements loop1.
- Stall: match with valid_i=0 for 3 cycles, then valid_i=1:
  - counter changes exactly once;
  - jump and target stable throughout.
- N_HWLP=3, regid=3 write of cnt=9: no register changes. Counter 0 with pc==end: no jump, dec=0.
- Assert rst_n mid-loop (cnt=4): all outputs 0 asynchronously; after release pc==end produces no jump.

Source files
------------

// File: rtl/riscv_hwloop_bank_pkg.sv
// Shared definitions for the hardware-loop register bank: write-enable bit
// positions, the default loop count and a register snapshot type.
package riscv_hwloop_pkg;

  // Bit positions inside the 3-bit hwlp_we_i write-enable vector
  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

  // Default number of hardware loops
  localparam int HWLP_N_DEFAULT = 2;

  // Snapshot of one loop's registers, for the controller and tracer
  typedef struct packed {
    logic [31:0] start;
    logic [31:0] end_addr;
    logic [31:0] cnt;
  } hwlp_regs_t;

  // Select width: $clog2 with a floor of one bit
  function automatic int hwlp_sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_hwloop_bank_if.sv
// Setup-write bus from the EX stage into the hardware-loop bank.
interface riscv_hwloop_bank_if #(
  parameter int N_HWLP_BITS = 1,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32
);
  logic [ADDR_W-1:0]      hwlp_start_data_i;
  logic [ADDR_W-1:0]      hwlp_end_data_i;
  logic [CNT_W-1:0]       hwlp_cnt_data_i;
  logic [2:0]             hwlp_we_i;
  logic [N_HWLP_BITS-1:0] hwlp_regid_i;

  // EX stage drives the setup writes
  modport master (
    output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
           hwlp_we_i, hwlp_regid_i
  );

  // The bank receives them
  modport slave (
    input hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i,
          hwlp_we_i, hwlp_regid_i
  );
endinterface

// File: rtl/riscv_hwloop_bank_match.sv
// N-way loop-end comparator with lowest-index (innermost) priority encoding.
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
#(
  parameter int N_HWLP      = HWLP_N_DEFAULT,
  parameter int N_HWLP_BITS = hwlp_sel_bits(N_HWLP),
  parameter int ADDR_W      = 32
) (
  input  logic [N_HWLP-1:0]        i_active,
  input  logic [N_HWLP*ADDR_W-1:0] i_end_addr,
  input  logic [ADDR_W-1:0]        i_pc,
  output logic [N_HWLP_BITS-1:0]   o_sel,
  output logic                     o_valid,
  output logic [N_HWLP-1:0]        o_onehot
);

  logic [N_HWLP-1:0] w_match;

  generate
    for (genvar gi = 0; gi < N_HWLP; gi++) begin : g_cmp
      assign w_match[gi] = i_active[gi] && (i_pc == i_end_addr[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Scan from the outermost loop down so the lowest matching index wins
  always_comb begin
    o_sel    = '0;
    o_onehot = '0;
    for (int k = N_HWLP - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_sel    = N_HWLP_BITS'(k);
        o_onehot = N_HWLP'(1) << k;
      end
    end
  end

  assign o_valid = |w_match;

endmodule

// File: rtl/riscv_hwloop_bank.sv
// Hardware-loop register bank: holds start/end/count per loop, detects the
// innermost loop end at the current PC, and applies the decrement itself.
module riscv_hwloop_bank
  import riscv_hwloop_pkg::*;
#(
  parameter int N_HWLP      = HWLP_N_DEFAULT,
  parameter int N_HWLP_BITS = hwlp_sel_bits(N_HWLP),
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_hwloop_bank_if.slave       wr_bus,
  input  logic                     valid_i,
  input  logic [ADDR_W-1:0]        current_pc_i,
  output logic [N_HWLP*ADDR_W-1:0] hwlp_start_addr_o,
  output logic [N_HWLP*ADDR_W-1:0] hwlp_end_addr_o,
  output logic [N_HWLP*CNT_W-1:0]  hwlp_counter_o,
  output logic [N_HWLP-1:0]        hwlp_active_o,
  output logic                     hwlp_jump_o,
  output logic [ADDR_W-1:0]        hwlp_targ_addr_o,
  output logic [N_HWLP-1:0]        hwlp_dec_o
);

  logic [ADDR_W-1:0] r_start [N_HWLP];
  logic [ADDR_W-1:0] r_end   [N_HWLP];
  logic [CNT_W-1:0]  r_cnt   [N_HWLP];
  logic [ADDR_W-1:0] r_targ;

  logic [N_HWLP_BITS-1:0] w_sel;
  logic                   w_hit;
  logic [N_HWLP-1:0]      w_onehot;
  logic [ADDR_W-1:0]      w_sel_start;
  logic [CNT_W-1:0]       w_sel_cnt;

  // Flatten the register file onto the output buses and derive activity
  generate
    for (genvar gi = 0; gi < N_HWLP; gi++) begin : g_flat
      assign hwlp_start_addr_o[gi*ADDR_W +: ADDR_W] = r_start[gi];
      assign hwlp_end_addr_o[gi*ADDR_W +: ADDR_W]   = r_end[gi];
      assign hwlp_counter_o[gi*CNT_W +: CNT_W]      = r_cnt[gi];
      assign hwlp_active_o[gi]                      = (r_cnt[gi] != '0);
    end
  endgenerate

  riscv_hwloop_match #(
    .N_HWLP      (N_HWLP),
    .N_HWLP_BITS (N_HWLP_BITS),
    .ADDR_W      (ADDR_W)
  ) u_match (
    .i_active   (hwlp_active_o),
    .i_end_addr (hwlp_end_addr_o),
    .i_pc       (current_pc_i),
    .o_sel      (w_sel),
    .o_valid    (w_hit),
    .o_onehot   (w_onehot)
  );

  assign w_sel_start = r_start[w_sel];
  assign w_sel_cnt   = r_cnt[w_sel];

  // Jump back unless this is the final iteration; fall-through still decrements
  assign hwlp_jump_o      = w_hit && (w_sel_cnt > CNT_W'(1));
  assign hwlp_dec_o       = w_hit ? w_onehot : '0;
  assign hwlp_targ_addr_o = w_hit ? w_sel_start : r_targ;

  // Register file: setup writes, then retire-gated decrement; write has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_HWLP; k++) begin
        r_start[k] <= '0;
        r_end[k]   <= '0;
        r_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < N_HWLP; k++) begin
        if (wr_bus.hwlp_we_i[HWLP_WE_START] && (32'(wr_bus.hwlp_regid_i) == k))
          r_start[k] <= wr_bus.hwlp_start_data_i;
        if (wr_bus.hwlp_we_i[HWLP_WE_END] && (32'(wr_bus.hwlp_regid_i) == k))
          r_end[k] <= wr_bus.hwlp_end_data_i;
        if (wr_bus.hwlp_we_i[HWLP_WE_CNT] && (32'(wr_bus.hwlp_regid_i) == k))
          r_cnt[k] <= wr_bus.hwlp_cnt_data_i;
        else if (hwlp_dec_o[k] && valid_i)
          r_cnt[k] <= r_cnt[k] - CNT_W'(1);
      end
    end
  end

  // Remember the last matched start so the target holds between matches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_targ <= '0;
    else if (w_hit)
      r_targ <= w_sel_start;
  end

`ifndef SYNTHESIS
  // At most one loop may be decremented per cycle
  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hwlp_dec_o));
`endif

endmodule

// File: tb/tb_riscv_hwloop_bank.sv
// Scoreboard bench for riscv_hwloop_bank with three loops.
module tb_riscv_hwloop_bank;
  localparam int N  = 3;
  localparam int NB = 2;
  localparam int AW = 32;
  localparam int CW = 32;

  typedef enum int {K_JUMP, K_TARG, K_DEC, K_ACT, K_CNT, K_START, K_END} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0;
  logic [AW-1:0] current_pc_i = '0;
  logic [N*AW-1:0] hwlp_start_addr_o, hwlp_end_addr_o;
  logic [N*CW-1:0] hwlp_counter_o;
  logic [N-1:0] hwlp_active_o, hwlp_dec_o;
  logic hwlp_jump_o;
  logic [AW-1:0] hwlp_targ_addr_o;

  int n_checks = 0;
  int n_errors = 0;
  sb_t sb_q[$];

  riscv_hwloop_bank_if #(.N_HWLP_BITS(NB), .ADDR_W(AW), .CNT_W(CW)) wr_bus ();

  riscv_hwloop_bank #(.N_HWLP(N), .N_HWLP_BITS(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_bus            (wr_bus.slave),
    .valid_i           (valid_i),
    .current_pc_i      (current_pc_i),
    .hwlp_start_addr_o (hwlp_start_addr_o),
    .hwlp_end_addr_o   (hwlp_end_addr_o),
    .hwlp_counter_o    (hwlp_counter_o),
    .hwlp_active_o     (hwlp_active_o),
    .hwlp_jump_o       (hwlp_jump_o),
    .hwlp_targ_addr_o  (hwlp_targ_addr_o),
    .hwlp_dec_o        (hwlp_dec_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] observe(input kind_t kind, input int idx);
    case (kind)
      K_JUMP:  return 32'(hwlp_jump_o);
      K_TARG:  return hwlp_targ_addr_o;
      K_DEC:   return 32'(hwlp_dec_o);
      K_ACT:   return 32'(hwlp_active_o);
      K_CNT:   return hwlp_counter_o[idx*CW +: CW];
      K_START: return hwlp_start_addr_o[idx*AW +: AW];
      default: return hwlp_end_addr_o[idx*AW +: AW];
    endcase
  endfunction

  task automatic push(input string tag, input kind_t kind, input int idx, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Settle, then pop every queued expectation and compare against the DUT
  task automatic drain();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  // Start a new cycle: drive PC/valid and an optional setup write
  task automatic cyc(input logic [31:0] pc, input logic v, input logic [2:0] we,
                     input logic [NB-1:0] id, input logic [31:0] s,
                     input logic [31:0] e, input logic [31:0] c);
    @(negedge clk);
    current_pc_i = pc;
    valid_i = v;
    wr_bus.hwlp_we_i = we;
    wr_bus.hwlp_regid_i = id;
    wr_bus.hwlp_start_data_i = s;
    wr_bus.hwlp_end_data_i = e;
    wr_bus.hwlp_cnt_data_i = c;
  endtask

  task automatic idle(input logic [31:0] pc, input logic v);
    cyc(pc, v, 3'b000, '0, '0, '0, '0);
  endtask

  initial begin
    wr_bus.hwlp_we_i = '0;
    wr_bus.hwlp_regid_i = '0;
    wr_bus.hwlp_start_data_i = '0;
    wr_bus.hwlp_end_data_i = '0;
    wr_bus.hwlp_cnt_data_i = '0;

    // Reset state
    #12;
    push("rst_cnt0", K_CNT, 0, 0); push("rst_act", K_ACT, 0, 0);
    push("rst_jump", K_JUMP, 0, 0); push("rst_targ", K_TARG, 0, 0);
    push("rst_dec", K_DEC, 0, 0);
    drain();
    @(negedge clk); rst_n = 1'b1;

    // Simple loop0: 3 iterations
    cyc(32'h0, 1'b0, 3'b111, 2'd0, 32'h100, 32'h10C, 3);
    idle(32'h10C, 1'b1);
    push("l0_start", K_START, 0, 32'h100); push("l0_end", K_END, 0, 32'h10C);
    push("l0_act", K_ACT, 0, 1); push("l0_cnt3", K_CNT, 0, 3);
    push("l0_jump1", K_JUMP, 0, 1); push("l0_targ1", K_TARG, 0, 32'h100);
    push("l0_dec1", K_DEC, 0, 1);
    drain();
    idle(32'h10C, 1'b1);
    push("l0_cnt2", K_CNT, 0, 2); push("l0_jump2", K_JUMP, 0, 1); push("l0_dec2", K_DEC, 0, 1);
    drain();
    idle(32'h10C, 1'b1);
    push("l0_cnt1", K_CNT, 0, 1); push("l0_jump3", K_JUMP, 0, 0);
    push("l0_dec3", K_DEC, 0, 1); push("l0_targ3", K_TARG, 0, 32'h100);
    drain();
    idle(32'h10C, 1'b1);
    push("l0_cnt0", K_CNT, 0, 0); push("l0_act0", K_ACT, 0, 0);
    push("l0_nojump", K_JUMP, 0, 0); push("l0_nodec", K_DEC, 0, 0);
    push("l0_targhold", K_TARG, 0, 32'h100);
    drain();

    // Nested loops sharing an end address
    cyc(32'h0, 1'b0, 3'b111, 2'd0, 32'h200, 32'h20C, 2);
    cyc(32'h0, 1'b0, 3'b111, 2'd1, 32'h1F0, 32'h20C, 5);
    idle(32'h20C, 1'b1);
    push("nest_dec0", K_DEC, 0, 1); push("nest_jump0", K_JUMP, 0, 1);
    push("nest_targ0", K_TARG, 0, 32'h200); push("nest_cnt1a", K_CNT, 1, 5);
    drain();
    idle(32'h20C, 1'b1);
    push("nest_dec0b", K_DEC, 0, 1); push("nest_fall0", K_JUMP, 0, 0);
    push("nest_cnt1b", K_CNT, 1, 5);
    drain();
    idle(32'h20C, 1'b1);
    push("nest_dec1", K_DEC, 0, 2); push("nest_jump1", K_JUMP, 0, 1);
    push("nest_targ1", K_TARG, 0, 32'h1F0); push("nest_cnt0", K_CNT, 0, 0);
    drain();
    idle(32'h0, 1'b0);
    push("nest_cnt1c", K_CNT, 1, 4);
    drain();

    // Same-cycle counter write beats decrement of the same loop
    cyc(32'h0, 1'b0, 3'b111, 2'd0, 32'h300, 32'h30C, 2);
    cyc(32'h30C, 1'b1, 3'b100, 2'd0, 32'h0, 32'h0, 7);
    push("wr_dec0", K_DEC, 0, 1);
    drain();
    cyc(32'h20C, 1'b1, 3'b100, 2'd0, 32'h0, 32'h0, 5);
    push("wr_cnt7", K_CNT, 0, 7); push("wr_dec1", K_DEC, 0, 2);
    drain();
    idle(32'h0, 1'b0);
    push("wr_cnt0_5", K_CNT, 0, 5); push("wr_cnt1_3", K_CNT, 1, 3);
    drain();

    // Stall: three non-retiring visits, then one retiring visit
    for (int i = 0; i < 3; i++) begin
      idle(32'h20C, 1'b0);
      push($sformatf("stall%0d_jump", i), K_JUMP, 0, 1);
      push($sformatf("stall%0d_targ", i), K_TARG, 0, 32'h1F0);
      push($sformatf("stall%0d_cnt", i), K_CNT, 1, 3);
      drain();
    end
    idle(32'h20C, 1'b1);
    push("stall_go_jump", K_JUMP, 0, 1); push("stall_go_cnt", K_CNT, 1, 3);
    drain();
    idle(32'h0, 1'b0);
    push("stall_after_cnt", K_CNT, 1, 2);
    drain();

    // Out-of-range regid write is dropped
    cyc(32'h0, 1'b0, 3'b111, 2'd3, 32'hAAA, 32'hBBB, 9);
    idle(32'h0, 1'b0);
    push("oor_cnt0", K_CNT, 0, 5); push("oor_cnt1", K_CNT, 1, 2);
    push("oor_cnt2", K_CNT, 2, 0); push("oor_start0", K_START, 0, 32'h300);
    push("oor_end2", K_END, 2, 0);
    drain();

    // Zero-count loop at its end address never matches or wraps
    cyc(32'h0, 1'b0, 3'b111, 2'd2, 32'h400, 32'h40C, 0);
    idle(32'h40C, 1'b1);
    push("z_jump", K_JUMP, 0, 0); push("z_dec", K_DEC, 0, 0);
    push("z_targ", K_TARG, 0, 32'h1F0);
    drain();
    idle(32'h0, 1'b0);
    push("z_cnt2", K_CNT, 2, 0);
    drain();

    // Asynchronous reset in the middle of a loop
    cyc(32'h0, 1'b0, 3'b111, 2'd0, 32'h500, 32'h50C, 4);
    idle(32'h50C, 1'b1);
    drain();
    idle(32'h50C, 1'b1);
    push("pre_rst_cnt", K_CNT, 0, 3);
    drain();
    #1 rst_n = 1'b0;
    push("arst_cnt0", K_CNT, 0, 0); push("arst_act", K_ACT, 0, 0);
    push("arst_jump", K_JUMP, 0, 0); push("arst_targ", K_TARG, 0, 0);
    push("arst_dec", K_DEC, 0, 0);
    drain();
    @(negedge clk); rst_n = 1'b1;
    idle(32'h50C, 1'b1);
    push("post_rst_jump", K_JUMP, 0, 0); push("post_rst_dec", K_DEC, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
